t_junction_sequencer: RTL and testbench
=======================================

# t_junction_sequencer

Parametrised multi-phase traffic-light sequencer for the T-intersection controller. It supersedes the fixed three-mode controller in four ways:
- per-phase green durations, phase count and counter width are parameters;
- amber and all-red clearance intervals are inserted between phases;
- a one-tick enable decouples the system clock from the 1 s timebase;
- a latched pedestrian request can be served as a dedicated WALK interval.

It sits between the timebase divider and the lamp drivers.

## Interface
- `N_PHASES`, 3, number of vehicle green phases, 2..4
- `CNT_W`, 8, interval counter width
- `GREEN_TICKS`, {8'd20, 8'd10, 8'd30}, packed N_PHASES*CNT_W vector; phase p duration at bits [p*CNT_W +: CNT_W] (phase0=30, phase1=10, phase2=20)
- `T_AMBER`, 3, amber ticks
- `T_ALLRED`, 2, all-red ticks
- `T_WALK`, 15, pedestrian walk ticks
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `tick_en`  in  1  one-clock timebase strobe; all intervals count tick_en pulses
- `ped_req`  in  1  pedestrian button, level, sampled every clock
- `green`  out  N_PHASES  one-hot green for the active phase; 0 outside GREEN
- `amber`  out  1  amber for the phase just ended
- `allred`  out  1  all-red clearance
- `walk`  out  1  pedestrian walk lamp
- `phase`  out  2  current/last vehicle phase index
- `ped_pending`  out  1  latched pedestrian request

## Operation
- States:
  - GREEN: duration GREEN_TICKS[phase]
  - AMBER: duration T_AMBER
  - ALLRED: duration T_ALLRED
  - WALK: duration T_WALK
- An internal post_walk flag marks an ALLRED that follows WALK.
- Transitions:
  - GREEN→AMBER.
  - AMBER→ALLRED.
  - ALLRED (post_walk=0) → WALK if (ped_pending | ped_req), else GREEN with phase ← (phase+1) mod N_PHASES.
  - WALK→ALLRED with post_walk=1.
  - ALLRED (post_walk=1) → GREEN with next phase, clearing post_walk.
- Interval counter:
  - On state entry it loads duration−1.
  - While tick_en=1 and cnt≠0 it decrements.
  - The state exits when tick_en=1 and cnt==0.
  - cnt holds when tick_en=0.
- Outputs are a Moore decode of registered state only; there is no input→output combinational path. Exactly one of {green≠0, amber, allred, walk} is active at all times.
- `phase` holds its value through AMBER, ALLRED and WALK. Phase wraps from N_PHASES−1 to 0.
- ped_pending:
  - Set on any clock with ped_req=1, except in WALK, where requests are ignored.
  - Cleared on the WALK entry edge; clear wins over a simultaneous set.
- Reset mid-operation abandons the current interval immediately; no amber is forced.
- Any duration parameter of 0, or a value ≥2^CNT_W, is illegal. It is caught by an elaboration-time check that stops elaboration (`$error`).

## Timing
- Reset values:
  - state=GREEN, phase=0, cnt=GREEN_TICKS[0]−1, post_walk=0
  - green=one-hot bit0, amber=0, allred=0, walk=0, ped_pending=0
- With tick_en held at 1, a state of duration D is visible for exactly D clocks.
- Cycle 0 is the first clock after rst deasserts. Nominal cycle with defaults, no pedestrian: 30+3+2+10+3+2+20+3+2 = 75 ticks.
- ped_pending rises one clock after ped_req is sampled high.
- A same-clock ped_req at the ALLRED exit does select WALK.
- Outputs change on the clock edge that changes state; latency from the qualifying tick_en is 1 clock.

## Configuration
- `TC_PED_WALK_EN` defined:
  - WALK state, post_walk flag and ped_pending latch are compiled in.
  - Behaviour is as above.
- Undefined:
  - ped_req is ignored.
  - ped_pending and walk are tied to 0.
  - WALK is unreachable and removed.
  - ALLRED always proceeds to the next GREEN.

## Test plan
- Reset, tick_en=1, ped_req=0:
  - green=001 for cycles 0–29, amber 30–32 with phase=0, allred 33–34;
  - green=010 at cycle 35, green=100 at cycle 50;
  - green=001 and phase=0 again at cycle 75.
- ped_req pulse one clock at cycle 5 (macro on):
  - ped_pending=1 at cycle 6;
  - walk=1 cycles 35–49, allred 50–51;
  - green=010 at cycle 52; ped_pending=0 from cycle 35.
- tick_en high one clock in four: phase 0 green lasts 120 clocks; cnt frozen on clocks without tick_en.
- rst asserted one clock during AMBER:
  - next clock green=001, phase=0, amber=0, ped_pending=0;
  - full 30-tick green follows.
- ped_req high only during WALK: ped_pending stays 0, and the next ALLRED goes straight to GREEN.
- Macro undefined, ped_req pulses at cycles 5 and 40: output trace identical to scenario 1, walk never 1.

Source files
------------

// File: rtl/t_junction_sequencer_if.sv
// Lamp/timebase bundle between the timebase divider, the sequencer and the lamp drivers.
interface t_junction_sequencer_if #(
  parameter int N_PHASES = 3
);
  logic                tick_en;
  logic                ped_req;
  logic [N_PHASES-1:0] green;
  logic                amber;
  logic                allred;
  logic                walk;
  logic [1:0]          phase;
  logic                ped_pending;

  modport master (
    output tick_en, ped_req,
    input  green, amber, allred, walk, phase, ped_pending
  );

  modport slave (
    input  tick_en, ped_req,
    output green, amber, allred, walk, phase, ped_pending
  );
endinterface

// File: rtl/t_junction_sequencer.sv
// Multi-phase T-junction light sequencer: GREEN -> AMBER -> ALLRED per phase, optional WALK.
// Define TC_PED_WALK_EN to compile in the pedestrian WALK interval and request latch.
module t_junction_sequencer #(
  parameter int                        N_PHASES    = 3,
  parameter int                        CNT_W       = 8,
  parameter logic [N_PHASES*CNT_W-1:0] GREEN_TICKS = {8'd20, 8'd10, 8'd30},
  parameter int                        T_AMBER     = 3,
  parameter int                        T_ALLRED    = 2,
  parameter int                        T_WALK      = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  t_junction_sequencer_if.slave   bus
);

  localparam logic [1:0]       P_LAST    = 2'(N_PHASES - 1);
  localparam logic [CNT_W-1:0] AMBER_LD  = CNT_W'(T_AMBER - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(T_ALLRED - 1);

  // Illegal configurations stop elaboration.
  if (N_PHASES < 2 || N_PHASES > 4) begin : g_bad_nphases
    $error("t_junction_sequencer: N_PHASES must be 2..4");
  end
  if (T_AMBER < 1 || T_AMBER >= (1 << CNT_W)) begin : g_bad_amber
    $error("t_junction_sequencer: T_AMBER out of range");
  end
  if (T_ALLRED < 1 || T_ALLRED >= (1 << CNT_W)) begin : g_bad_allred
    $error("t_junction_sequencer: T_ALLRED out of range");
  end
  if (T_WALK < 1 || T_WALK >= (1 << CNT_W)) begin : g_bad_walk
    $error("t_junction_sequencer: T_WALK out of range");
  end

  // Per-phase reload values; unused slots up to the 2-bit phase range read as zero.
  logic [CNT_W-1:0] green_ld [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_ld
    if (gi < N_PHASES) begin : g_used
      if (GREEN_TICKS[gi*CNT_W +: CNT_W] == '0) begin : g_bad_green
        $error("t_junction_sequencer: zero green duration");
      end
      assign green_ld[gi] = GREEN_TICKS[gi*CNT_W +: CNT_W] - CNT_W'(1);
    end else begin : g_unused
      assign green_ld[gi] = '0;
    end
  end

`ifdef TC_PED_WALK_EN
  localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(T_WALK - 1);
  typedef enum logic [1:0] {S_GREEN, S_AMBER, S_ALLRED, S_WALK} state_t;
`else
  typedef enum logic [1:0] {S_GREEN, S_AMBER, S_ALLRED} state_t;
`endif

  state_t              state_reg;
  logic [1:0]          phase_reg;
  logic [1:0]          phase_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [N_PHASES-1:0] green_reg;
  logic                amber_reg;
  logic                allred_reg;

  assign phase_next = (phase_reg == P_LAST) ? 2'd0 : phase_reg + 2'd1;

`ifdef TC_PED_WALK_EN
  logic post_walk_reg;
  logic ped_pending_reg;
  logic walk_reg;
`else
  logic unused_ped_req;
  assign unused_ped_req = bus.ped_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_GREEN;
      phase_reg       <= 2'd0;
      cnt_reg         <= green_ld[0];
      green_reg       <= N_PHASES'(1);
      amber_reg       <= 1'b0;
      allred_reg      <= 1'b0;
`ifdef TC_PED_WALK_EN
      post_walk_reg   <= 1'b0;
      ped_pending_reg <= 1'b0;
      walk_reg        <= 1'b0;
`endif
    end else begin
`ifdef TC_PED_WALK_EN
      // Set first so a WALK entry on the same edge overrides it below.
      if (bus.ped_req && state_reg != S_WALK) ped_pending_reg <= 1'b1;
`endif
      if (bus.tick_en) begin
        if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end else begin
          unique case (state_reg)
            S_GREEN: begin
              state_reg <= S_AMBER;
              cnt_reg   <= AMBER_LD;
              green_reg <= '0;
              amber_reg <= 1'b1;
            end
            S_AMBER: begin
              state_reg  <= S_ALLRED;
              cnt_reg    <= ALLRED_LD;
              amber_reg  <= 1'b0;
              allred_reg <= 1'b1;
            end
            S_ALLRED: begin
`ifdef TC_PED_WALK_EN
              if (!post_walk_reg && (ped_pending_reg || bus.ped_req)) begin
                state_reg       <= S_WALK;
                cnt_reg         <= WALK_LD;
                allred_reg      <= 1'b0;
                walk_reg        <= 1'b1;
                ped_pending_reg <= 1'b0;
              end else begin
                post_walk_reg <= 1'b0;
                state_reg     <= S_GREEN;
                phase_reg     <= phase_next;
                cnt_reg       <= green_ld[phase_next];
                green_reg     <= N_PHASES'(1) << phase_next;
                allred_reg    <= 1'b0;
              end
`else
              state_reg  <= S_GREEN;
              phase_reg  <= phase_next;
              cnt_reg    <= green_ld[phase_next];
              green_reg  <= N_PHASES'(1) << phase_next;
              allred_reg <= 1'b0;
`endif
            end
`ifdef TC_PED_WALK_EN
            S_WALK: begin
              state_reg     <= S_ALLRED;
              cnt_reg       <= ALLRED_LD;
              post_walk_reg <= 1'b1;
              walk_reg      <= 1'b0;
              allred_reg    <= 1'b1;
            end
`endif
            default: begin
              state_reg <= S_GREEN;
            end
          endcase
        end
      end
    end
  end

  assign bus.green  = green_reg;
  assign bus.amber  = amber_reg;
  assign bus.allred = allred_reg;
  assign bus.phase  = phase_reg;
`ifdef TC_PED_WALK_EN
  assign bus.walk        = walk_reg;
  assign bus.ped_pending = ped_pending_reg;
`else
  assign bus.walk        = 1'b0;
  assign bus.ped_pending = 1'b0;
`endif

endmodule

// File: tb/tb_t_junction_sequencer.sv
// Directed plus randomized bench for t_junction_sequencer against an interval-level model.
module tb_t_junction_sequencer;
  localparam int NP = 3;
  localparam int GDUR [NP] = '{30, 10, 20};
  localparam int K_GREEN = 0, K_AMBER = 1, K_ALLRED = 2, K_WALK = 3;
`ifdef TC_PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  t_junction_sequencer_if #(.N_PHASES(NP)) bus ();

  t_junction_sequencer #(.N_PHASES(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: which interval is showing, how many ticks of it have elapsed.
  int m_kind, m_done, m_phase;
  bit m_post, m_pend;

  function automatic int dur_of(input int k, input int p);
    case (k)
      K_GREEN:  return GDUR[p];
      K_AMBER:  return 3;
      K_ALLRED: return 2;
      default:  return 15;
    endcase
  endfunction

  function automatic string kind_name(input int k);
    case (k)
      K_GREEN:  return "GREEN";
      K_AMBER:  return "AMBER";
      K_ALLRED: return "ALLRED";
      default:  return "WALK";
    endcase
  endfunction

  task automatic model_clock(input bit r, input bit te, input bit pr);
    bit req;
    if (r) begin
      m_kind = K_GREEN; m_done = 0; m_phase = 0; m_post = 0; m_pend = 0;
      return;
    end
    req = m_pend | pr;
    if (PED_EN && pr && m_kind != K_WALK) m_pend = 1;
    if (te) begin
      m_done++;
      if (m_done == dur_of(m_kind, m_phase)) begin
        m_done = 0;
        case (m_kind)
          K_GREEN:  m_kind = K_AMBER;
          K_AMBER:  m_kind = K_ALLRED;
          K_ALLRED: begin
            if (PED_EN && !m_post && req) begin
              m_kind = K_WALK;
              m_pend = 0;
            end else begin
              m_kind  = K_GREEN;
              m_phase = (m_phase + 1) % NP;
              m_post  = 0;
            end
          end
          default: begin
            m_kind = K_ALLRED;
            m_post = 1;
          end
        endcase
        $display("[TB] cyc=%0d enter %s phase=%0d pend=%0d", cyc + 1, kind_name(m_kind), m_phase, m_pend);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare every output.
  task automatic run_cycle(input bit r, input bit te, input bit pr);
    logic [NP-1:0] g;
    logic [8:0]    exp_v, obs_v;
    rst         = r;
    bus.tick_en = te;
    bus.ped_req = pr;
    @(posedge clk);
    model_clock(r, te, pr);
    #1;
    cyc = r ? 0 : cyc + 1;
    g = '0;
    if (m_kind == K_GREEN) g[m_phase] = 1'b1;
    exp_v = {g, m_kind == K_AMBER, m_kind == K_ALLRED, m_kind == K_WALK, 2'(m_phase), m_pend};
    obs_v = {bus.green, bus.amber, bus.allred, bus.walk, bus.phase, bus.ped_pending};
    chk($sformatf("trace_c%0d", cyc), 32'(obs_v), 32'(exp_v));
  endtask

  initial begin
    bus.tick_en = 1'b0;
    bus.ped_req = 1'b0;

    // Scenario 1: free-running nominal cycle.
    run_cycle(1, 1, 0);
    chk("rst_green", 32'(bus.green), 32'b001);
    chk("rst_lamps", 32'({bus.amber, bus.allred, bus.walk, bus.ped_pending}), 32'b0);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    while (cyc < 76) begin
      if (cyc == 29) chk("s1_c29_green", 32'(bus.green), 32'b001);
      if (cyc == 30) chk("s1_c30_amber", 32'({bus.amber, bus.phase}), 32'b100);
      if (cyc == 32) chk("s1_c32_amber", 32'(bus.amber), 32'd1);
      if (cyc == 33) chk("s1_c33_allred", 32'(bus.allred), 32'd1);
      if (cyc == 35) chk("s1_c35_green", 32'(bus.green), 32'b010);
      if (cyc == 50) chk("s1_c50_green", 32'(bus.green), 32'b100);
      if (cyc == 75) chk("s1_c75_wrap", 32'({bus.green, bus.phase}), 32'b00100);
      run_cycle(0, 1, 0);
    end

`ifdef TC_PED_WALK_EN
    // Scenario 2: single pedestrian pulse served after phase 0.
    run_cycle(1, 1, 0);
    while (cyc < 53) begin
      if (cyc == 6)  chk("s2_c6_pend", 32'(bus.ped_pending), 32'd1);
      if (cyc == 35) chk("s2_c35_walk", 32'({bus.walk, bus.ped_pending}), 32'b10);
      if (cyc == 49) chk("s2_c49_walk", 32'(bus.walk), 32'd1);
      if (cyc == 50) chk("s2_c50_allred", 32'(bus.allred), 32'd1);
      if (cyc == 52) chk("s2_c52_green", 32'(bus.green), 32'b010);
      run_cycle(0, 1, cyc == 5);
    end

    // Scenario 5: requests held only during WALK are ignored.
    run_cycle(1, 1, 0);
    while (cyc < 53) begin
      if (cyc == 50) chk("s5_c50_pend", 32'(bus.ped_pending), 32'd0);
      if (cyc == 52) chk("s5_c52_green", 32'(bus.green), 32'b010);
      run_cycle(0, 1, (cyc == 5) || (cyc >= 35 && cyc <= 49));
    end
`else
    // Scenario 6: pedestrian pulses have no effect without the walk feature.
    run_cycle(1, 1, 0);
    while (cyc < 76) begin
      if (cyc == 35) chk("s6_c35_green", 32'(bus.green), 32'b010);
      if (cyc == 50) chk("s6_c50_green", 32'(bus.green), 32'b100);
      chk("s6_walk_off", 32'({bus.walk, bus.ped_pending}), 32'd0);
      run_cycle(0, 1, cyc == 5 || cyc == 40);
    end
`endif

    // Scenario 3: one tick every four clocks stretches phase 0 green to 120 clocks.
    run_cycle(1, 0, 0);
    while (cyc < 122) begin
      if (cyc == 119) chk("s3_c119_green", 32'(bus.green), 32'b001);
      if (cyc == 120) chk("s3_c120_amber", 32'(bus.amber), 32'd1);
      run_cycle(0, (cyc % 4) == 3, 0);
    end

    // Scenario 4: reset pulse during AMBER abandons it.
    run_cycle(1, 1, 0);
    while (cyc < 31) run_cycle(0, 1, cyc == 5);
    chk("s4_in_amber", 32'(bus.amber), 32'd1);
    run_cycle(1, 1, 0);
    chk("s4_after_rst", 32'({bus.green, bus.amber, bus.phase, bus.ped_pending}), 32'b0010000);
    while (cyc < 31) begin
      if (cyc == 29) chk("s4_c29_green", 32'(bus.green), 32'b001);
      if (cyc == 30) chk("s4_c30_amber", 32'(bus.amber), 32'd1);
      run_cycle(0, 1, 0);
    end

    // Randomized: irregular timebase, sparse button presses, rare resets.
    for (int i = 0; i < 1500; i++) begin
      run_cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
